encode_posit_8bit_pipe: RTL and testbench
=========================================

Name: encode_posit_8bit_pipe

Overview:
Pipelined encoder that converts 12-bit extended posits (eposit) back into 8-bit posits (es=0). It is the downstream stage of decode_posit_8bit and the output stage of the 8-bit posit datapath (decode -> op -> encode). Input and output use valid/ready streams with full throughput and backpressure. Encoding is the exact inverse of the decoder for every canonical eposit.

Parameters:
STAGES, 2, pipeline depth; legal values 1 or 2. Latency equals STAGES cycles.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  eposit valid
in_ready  output  1  stage can accept
in_eposit  input  12  {inf, zero, sign, regime[3:0], frac[4:0]}
out_valid  output  1  posit valid
out_ready  input  1  consumer accepts
out_posit  output  8  encoded posit
out_err  output  1  malformed input flag, aligned with out_posit
err_sticky  output  1  latched out_err, cleared by err_clr
err_clr  input  1  clears err_sticky

Behaviour:
- One clock domain, clk. rst is synchronous and active-high.
- Reset values: all stage valids 0, out_valid 0, out_posit 0x00, out_err 0, err_sticky 0. in_ready is 1 in the cycle after reset. An rst asserted mid-stream discards all in-flight data without producing output.
- Handshakes:
  - A transfer occurs when valid and ready are both 1.
  - Each stage loads when it is empty or its contents leave in the same cycle.
  - in_ready = ~s1_valid | s1_advance, where s1_advance = the transfer out of stage 1 in that cycle.
  - out_valid and out_posit stay stable while out_ready = 0.
  - in_ready must not combinationally depend on in_valid.
  - Sustained in_valid with out_ready = 1 gives one result per cycle.
- Encoding (inf has priority over zero):
  - inf -> 0x80.
  - zero -> 0x00.
  - Otherwise, with s = sign and r = regime:
    - r >= 7: run bit b = ~s, run length L = r - 6.
    - r <= 6: b = s, L = 7 - r (r = 0 gives L = 7).
  - posit[7] = s. posit[6:7-L] = L copies of b.
  - If L < 7: the terminator ~b goes at bit 6-L.
  - posit[5-L:0] = frac[4:L-1] (fraction is left-aligned); frac bits below L-1 are dropped.
- Stage split (STAGES = 2):
  - Stage 1 registers s, b, L one-hot, frac, special flags and the err term.
  - Stage 2 assembles and registers the posit.
  - STAGES = 1 registers only the final posit.
- Malformed input: out_err = 1 when any of the following holds; the encoding rules above still apply.
  - r > 13: clamp r to 13.
  - s = 0 and r = 0.
  - inf and zero both set.
  - A special flag set while sign, regime or frac differ from the canonical value. Canonical inf = sign 1, regime 13, frac 0. Canonical zero = all fields 0.
  - Nonzero dropped frac bits.
- err_sticky:
  - Sets in the cycle an out_err = 1 result transfers out.
  - err_clr clears it. If a set and err_clr occur in the same cycle, the set wins.

Optional Feature:
Macro MULLIN_ENC_CHECK_EN.
- Defined: malformed detection, out_err and err_sticky behave as specified above.
- Undefined: detection logic is absent. out_err and err_sticky are tied to 0, err_clr is ignored, and r > 13 is still clamped. Ports exist in both builds.

Decomposition:
Package mullin_posit8_pkg holds:
- EPOSIT_W = 12.
- Field index constants: INF_BIT = 11, ZERO_BIT = 10, SIGN_BIT = 9, REGIME_MSB/LSB = 8/5, FRAC_MSB/LSB = 4/0.
- REGIME_BIAS = 7, REGIME_MAX = 13.
- Canonical EPOSIT_INF = 12'hBA0 and EPOSIT_ZERO = 12'h400.
- POSIT_NAR = 8'h80.

One combinational sub-module, enc_regime_run_8bit: maps {sign, regime} to run bit b, L one-hot[6:0] and fraction keep-mask.

Test Plan:
- Round trip: all 256 posits through decode_posit_8bit into this block, out_ready = 1 -> out_posit equals input in order, latency STAGES, out_err = 0 throughout.
- Specials: eposit 12'hBA0 -> 0x80. 12'h400 -> 0x00. 12'hC00 (inf and zero both set) -> 0x80 with out_err = 1.
- Backpressure: stream 0x01..0x10 (decoded) with out_ready toggling pseudo-randomly -> no loss or duplication, and out_posit held while stalled.
- Malformed: regime 15, sign 0, frac 0 -> 0x7F with out_err = 1 and err_sticky = 1. err_clr then clears it. Regime 13, sign 0, frac 5'h10 -> 0x7F with out_err = 1 (dropped bit).
- Reset mid-stream: assert rst with both stages full -> out_valid = 0 the next cycle, no stale output afterward, in_ready = 1.
- Build without MULLIN_ENC_CHECK_EN: repeat the malformed case -> same out_posit, out_err = 0, err_sticky = 0.

Source files
------------

// File: rtl/mullin_posit8_pkg.sv
// Shared constants, stage record and posit assembly helper for the 8-bit posit (es=0) datapath.
package mullin_posit8_pkg;

    localparam int unsigned EPOSIT_W   = 12;
    localparam int unsigned INF_BIT    = 11;
    localparam int unsigned ZERO_BIT   = 10;
    localparam int unsigned SIGN_BIT   = 9;
    localparam int unsigned REGIME_MSB = 8;
    localparam int unsigned REGIME_LSB = 5;
    localparam int unsigned FRAC_MSB   = 4;
    localparam int unsigned FRAC_LSB   = 0;

    localparam logic [3:0] REGIME_BIAS = 4'd7;
    localparam logic [3:0] REGIME_MAX  = 4'd13;

    localparam logic [EPOSIT_W-1:0] EPOSIT_INF  = 12'hBA0;
    localparam logic [EPOSIT_W-1:0] EPOSIT_ZERO = 12'h400;
    localparam logic [7:0]          POSIT_NAR   = 8'h80;

    typedef enum logic [1:0] {
        KIND_NORMAL = 2'd0,
        KIND_ZERO   = 2'd1,
        KIND_INF    = 2'd2
    } enc_kind_t;

    typedef struct packed {
        enc_kind_t  kind;
        logic       sgn;
        logic       run_bit;
        logic [6:0] l_onehot;
        logic [4:0] frac;
        logic       err;
    } enc_stage_t;

    // Run of L bits, then the terminator and the left-aligned fraction shifted down by L.
    function automatic logic [7:0] assemble_posit(input enc_stage_t st);
        logic [6:0] run_mask;
        logic [6:0] tail;
        logic [6:0] body;
        logic [7:0] res;
        run_mask = '0;
        tail     = '0;
        body     = '0;
        for (int unsigned k = 0; k < 7; k++) begin
            if (st.l_onehot[k]) begin
                run_mask = 7'h7F << (6 - k);
                tail     = {~st.run_bit, st.frac, 1'b0} >> (k + 1);
                body     = (st.run_bit ? run_mask : 7'h00) | tail;
            end
        end
        case (st.kind)
            KIND_INF:  res = POSIT_NAR;
            KIND_ZERO: res = 8'h00;
            default:   res = {st.sgn, body};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/enc_regime_run_8bit.sv
// Maps {sign, clamped regime} to the regime run bit, one-hot run length and fraction keep-mask.
module enc_regime_run_8bit
    import mullin_posit8_pkg::*;
(
    input  logic       i_sign,
    input  logic [3:0] i_regime,
    output logic       o_run_bit,
    output logic [6:0] o_l_onehot,
    output logic [4:0] o_keep_mask
);

    logic       w_up;
    logic [3:0] w_len_m1;

    always_comb begin
        w_up        = (i_regime >= REGIME_BIAS);
        o_run_bit   = w_up ? ~i_sign : i_sign;
        // L - 1: r >= 7 gives r - 7, otherwise 6 - r
        w_len_m1    = w_up ? (i_regime - REGIME_BIAS) : (4'd6 - i_regime);
        o_l_onehot  = 7'b000_0001 << w_len_m1;
        o_keep_mask = 5'h1F << w_len_m1;
    end

endmodule

// File: rtl/encode_posit_8bit_pipe.sv
// Pipelined eposit -> 8-bit posit encoder with valid/ready streams (STAGES = 1 or 2).
// Malformed-input detection, out_err and err_sticky are built only with MULLIN_ENC_CHECK_EN.
module encode_posit_8bit_pipe
    import mullin_posit8_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_eposit,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_posit,
    output logic        out_err,
    output logic        err_sticky,
    input  logic        err_clr
);

    logic       w_inf;
    logic       w_zero;
    logic       w_sign;
    logic [3:0] w_regime_raw;
    logic [3:0] w_regime;
    logic [4:0] w_frac;
    logic       w_run_bit;
    logic [6:0] w_l_onehot;
    logic [4:0] w_keep_mask;
    logic       w_err;
    enc_stage_t w_front;

    logic       w_in_ready;
    logic       w_load_out;
    logic [7:0] w_next_posit;
    logic       w_next_err;

    logic       r_out_valid;
    logic [7:0] r_out_posit;
    logic       r_out_err;

    assign w_inf        = in_eposit[INF_BIT];
    assign w_zero       = in_eposit[ZERO_BIT];
    assign w_sign       = in_eposit[SIGN_BIT];
    assign w_regime_raw = in_eposit[REGIME_MSB:REGIME_LSB];
    assign w_frac       = in_eposit[FRAC_MSB:FRAC_LSB];
    assign w_regime     = (w_regime_raw > REGIME_MAX) ? REGIME_MAX : w_regime_raw;

    enc_regime_run_8bit u_run (
        .i_sign      (w_sign),
        .i_regime    (w_regime),
        .o_run_bit   (w_run_bit),
        .o_l_onehot  (w_l_onehot),
        .o_keep_mask (w_keep_mask)
    );

`ifdef MULLIN_ENC_CHECK_EN
    logic [SIGN_BIT:0] w_fields;
    logic              w_special;
    logic              w_inf_bad;
    logic              w_zero_bad;
    logic              w_norm_bad;

    always_comb begin
        w_fields   = in_eposit[SIGN_BIT:0];
        w_special  = w_inf | w_zero;
        w_inf_bad  = w_inf & (w_fields != EPOSIT_INF[SIGN_BIT:0]);
        w_zero_bad = w_zero & (w_fields != EPOSIT_ZERO[SIGN_BIT:0]);
        // Range, sign/regime and dropped-fraction checks only make sense for ordinary values
        w_norm_bad = (w_regime_raw > REGIME_MAX)
                   | (~w_sign & (w_regime_raw == 4'd0))
                   | (|(w_frac & ~w_keep_mask));
        w_err      = (w_inf & w_zero) | w_inf_bad | w_zero_bad | (~w_special & w_norm_bad);
    end
`else
    logic w_unused_nochk;
    assign w_unused_nochk = ^{err_clr, w_keep_mask};
    assign w_err          = 1'b0;
`endif

    always_comb begin
        w_front          = '0;
        w_front.kind     = w_inf ? KIND_INF : (w_zero ? KIND_ZERO : KIND_NORMAL);
        w_front.sgn      = w_sign;
        w_front.run_bit  = w_run_bit;
        w_front.l_onehot = w_l_onehot;
        w_front.frac     = w_frac;
        w_front.err      = w_err;
    end

    generate
        if (STAGES == 1) begin : gen_one_stage
            assign w_in_ready   = ~r_out_valid | out_ready;
            assign w_load_out   = in_valid & w_in_ready;
            assign w_next_posit = assemble_posit(w_front);
            assign w_next_err   = w_front.err;
        end else begin : gen_two_stage
            logic       r_s1_valid;
            enc_stage_t r_s1;
            logic       w_s1_adv;

            assign w_s1_adv     = r_s1_valid & (~r_out_valid | out_ready);
            assign w_in_ready   = ~r_s1_valid | w_s1_adv;
            assign w_load_out   = w_s1_adv;
            assign w_next_posit = assemble_posit(r_s1);
            assign w_next_err   = r_s1.err;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1_valid <= 1'b0;
                    r_s1       <= '0;
                end else begin
                    if (w_in_ready) r_s1_valid <= in_valid;
                    if (w_in_ready & in_valid) r_s1 <= w_front;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_posit <= 8'h00;
            r_out_err   <= 1'b0;
        end else begin
            if (~r_out_valid | out_ready) r_out_valid <= w_load_out;
            if (w_load_out) begin
                r_out_posit <= w_next_posit;
                r_out_err   <= w_next_err;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_posit = r_out_posit;
    assign out_err   = r_out_err;

`ifdef MULLIN_ENC_CHECK_EN
    logic r_err_sticky;

    // A flagged result leaving the block beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
        end else if (r_out_valid & out_ready & r_out_err) begin
            r_err_sticky <= 1'b1;
        end else if (err_clr) begin
            r_err_sticky <= 1'b0;
        end
    end

    assign err_sticky = r_err_sticky;
`else
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_encode_posit_8bit_pipe.sv
// Self-checking bench for encode_posit_8bit_pipe against a bit-placement reference model.
module tb_encode_posit_8bit_pipe;

    localparam int unsigned STAGES = 2;
`ifdef MULLIN_ENC_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_eposit;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_posit;
    logic        out_err;
    logic        err_sticky;
    logic        err_clr;

    int          n_chk = 0;
    int          n_err = 0;
    int          n_pop = 0;
    logic [8:0]  exp_q[$];
    bit          hold_pending = 1'b0;
    logic [7:0]  hold_posit = 8'h00;
    bit          exp_sticky = 1'b0;
    bit          acc = 1'b0;
    bit          smp_ov = 1'b0;
    logic [7:0]  last_posit = 8'h00;
    logic        last_err = 1'b0;

    encode_posit_8bit_pipe #(.STAGES(STAGES)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_eposit  (in_eposit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_posit  (out_posit),
        .out_err    (out_err),
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: place the run, terminator and fraction bits one at a time from bit 6 down.
    function automatic logic [8:0] ref_enc(input logic [11:0] e);
        bit         inf, zero, s, b, err;
        int         r, len, pos;
        logic [4:0] f;
        logic [7:0] p;
        inf  = e[11];
        zero = e[10];
        s    = e[9];
        r    = int'(e[8:5]);
        f    = e[4:0];
        err  = 1'b0;
        p    = 8'h00;
        if (inf && zero) err = 1'b1;
        if (inf && !(s == 1'b1 && r == 13 && f == 5'd0)) err = 1'b1;
        if (zero && !(s == 1'b0 && r == 0 && f == 5'd0)) err = 1'b1;
        if (inf) begin
            p = 8'h80;
        end else if (zero) begin
            p = 8'h00;
        end else begin
            if (r > 13) begin
                err = 1'b1;
                r   = 13;
            end
            if (!s && r == 0) err = 1'b1;
            if (r >= 7) begin
                b   = !s;
                len = r - 6;
            end else begin
                b   = s;
                len = 7 - r;
            end
            p[7] = s;
            pos  = 6;
            for (int i = 0; i < len; i++) begin
                p[pos] = b;
                pos--;
            end
            if (pos >= 0) begin
                p[pos] = !b;
                pos--;
            end
            for (int fi = 4; fi >= 0; fi--) begin
                if (pos >= 0) begin
                    p[pos] = f[fi];
                    pos--;
                end else if (f[fi]) begin
                    err = 1'b1;
                end
            end
        end
        if (!CHK_EN) err = 1'b0;
        return {err, p};
    endfunction

    // Inverse mapping: read a posit back into its canonical eposit.
    function automatic logic [11:0] dec(input logic [7:0] p);
        bit         s, b;
        int         len, pos, fi, r;
        logic [4:0] f;
        if (p == 8'h00) return 12'h400;
        if (p == 8'h80) return 12'hBA0;
        s   = p[7];
        b   = p[6];
        len = 0;
        pos = 6;
        while (pos >= 0 && p[pos] == b) begin
            len++;
            pos--;
        end
        if (pos >= 0) pos--;
        f  = 5'd0;
        fi = 4;
        while (pos >= 0) begin
            f[fi] = p[pos];
            fi--;
            pos--;
        end
        r = (b != s) ? len + 6 : 7 - len;
        return {1'b0, 1'b0, s, 4'(r), f};
    endfunction

    task automatic cycle(input bit v, input logic [11:0] e, input bit ordy, input bit clr);
        logic [8:0] x;
        bit         nxt;
        in_valid  = v;
        in_eposit = e;
        out_ready = ordy;
        err_clr   = clr;
        @(negedge clk);
        smp_ov = out_valid;
        acc    = in_valid && in_ready;
        if (hold_pending) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_posit", 32'(out_posit), 32'(hold_posit));
        end
        check("sticky", 32'(err_sticky), 32'(exp_sticky));
        nxt = exp_sticky;
        if (clr) nxt = 1'b0;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                x = exp_q.pop_front();
                n_pop++;
                check("posit", 32'(out_posit), 32'(x[7:0]));
                check("err", 32'(out_err), 32'(x[8]));
                last_posit = out_posit;
                last_err   = out_err;
                if (x[8]) nxt = 1'b1;
            end
        end
        hold_pending = out_valid && !out_ready;
        hold_posit   = out_posit;
        if (acc) exp_q.push_back(ref_enc(e));
        exp_sticky = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            cycle(1'b0, 12'h000, 1'b1, 1'b0);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int         lat;
        int         n_acc;
        int         idx;
        int         budget;
        int         pops0;
        logic [7:0] pv;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_eposit = 12'h000;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_posit", 32'(out_posit), 32'h00);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_sticky", 32'(err_sticky), 32'd0);
        @(posedge clk);
        #1;

        // Latency of an isolated transfer
        cycle(1'b1, dec(8'h40), 1'b1, 1'b0);
        lat = 0;
        do begin
            lat++;
            cycle(1'b0, 12'h000, 1'b1, 1'b0);
        end while (!smp_ov && lat < 10);
        check("latency", 32'(lat), 32'(STAGES));
        drain();
        check("lat_posit", 32'(last_posit), 32'h40);

        // Round trip of every posit at full rate
        n_acc = 0;
        for (int p = 0; p < 256; p++) begin
            pv = 8'(p);
            cycle(1'b1, dec(pv), 1'b1, 1'b0);
            if (acc) n_acc++;
        end
        check("rt_accepted", 32'(n_acc), 32'd256);
        drain();
        check("rt_last", 32'(last_posit), 32'hFF);

        // Specials
        cycle(1'b1, 12'hBA0, 1'b1, 1'b0);
        drain();
        check("inf_posit", 32'(last_posit), 32'h80);
        check("inf_err", 32'(last_err), 32'd0);
        cycle(1'b1, 12'h400, 1'b1, 1'b0);
        drain();
        check("zero_posit", 32'(last_posit), 32'h00);
        check("zero_err", 32'(last_err), 32'd0);
        cycle(1'b1, 12'hC00, 1'b1, 1'b0);
        drain();
        check("infzero_posit", 32'(last_posit), 32'h80);
        check("infzero_err", 32'(last_err), 32'(CHK_EN));
        cycle(1'b0, 12'h000, 1'b1, 1'b1);

        // Malformed: regime above range, then a dropped fraction bit
        cycle(1'b1, 12'h1E0, 1'b1, 1'b0);
        drain();
        check("r15_posit", 32'(last_posit), 32'h7F);
        check("r15_err", 32'(last_err), 32'(CHK_EN));
        check("r15_sticky", 32'(err_sticky), 32'(CHK_EN));
        cycle(1'b0, 12'h000, 1'b1, 1'b1);
        check("sticky_clr", 32'(err_sticky), 32'd0);
        cycle(1'b1, 12'h1B0, 1'b1, 1'b0);
        drain();
        check("drop_posit", 32'(last_posit), 32'h7F);
        check("drop_err", 32'(last_err), 32'(CHK_EN));
        cycle(1'b0, 12'h000, 1'b1, 1'b1);

        // Backpressure stream 0x01..0x10
        idx    = 1;
        budget = 0;
        pops0  = n_pop;
        while (idx <= 16 && budget < 400) begin
            pv = 8'(idx);
            cycle(1'b1, dec(pv), 1'($urandom_range(0, 1)), 1'b0);
            if (acc) idx++;
            budget++;
        end
        check("bp_accepted", 32'(idx), 32'd17);
        drain();
        check("bp_count", 32'(n_pop - pops0), 32'd16);
        check("bp_last", 32'(last_posit), 32'h10);

        // Reset with both stages full
        cycle(1'b1, dec(8'h40), 1'b0, 1'b0);
        cycle(1'b1, dec(8'h41), 1'b0, 1'b0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        hold_pending = 1'b0;
        exp_sticky   = 1'b0;
        @(negedge clk);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        repeat (5) cycle(1'b0, 12'h000, 1'b1, 1'b0);

        // Random eposits, random backpressure and clears
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), 12'($urandom), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 7) == 0));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
